regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 32×64-bit register file. It shares the register file's single write port among `NREQ` write-back requesters (ALU, load unit, debug loader) using a round-robin valid/ready handshake. It drives the write port through registered outputs and tracks which destination registers have writes pending. It sits between the execute/memory stages and the register file write port, and answers read-operand hazard queries for the issue stage.

---
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file write port.
// It also keeps a pending-write scoreboard that answers operand hazard queries.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64,
  parameter int PW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic [4:0]           reg_num_w,
  output logic [XLEN-1:0]      w_data,
  output logic                 ctrl_reg_w,
  output logic [PW-1:0]        grant_idx,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           chk_rs1,
  input  logic [4:0]           chk_rs2,
  output logic                 busy_rs1,
  output logic                 busy_rs2
);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   grant_idx_q, grant_idx_d;
  logic [4:0]      reg_num_w_q, reg_num_w_d;
  logic [XLEN-1:0] w_data_q, w_data_d;
  logic            ctrl_reg_w_q, ctrl_reg_w_d;
  logic [31:0]     busy_q, busy_d;

  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  // (base + k) mod NREQ for base < NREQ and k < NREQ
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[rr_index(ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_index(ptr_q, k);
      end
    end
  end

  assign sel_rd   = req_rd[5*int'(gnt_idx) +: 5];
  assign sel_data = req_data[XLEN*int'(gnt_idx) +: XLEN];

  // The handshake completes only while out of reset, so ready is masked by rst_n.
  assign req_ready = (rst_n && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    ptr_d        = ptr_q;
    grant_idx_d  = grant_idx_q;
    reg_num_w_d  = reg_num_w_q;
    w_data_d     = w_data_q;
    ctrl_reg_w_d = 1'b0;
    busy_d       = busy_q;
    if (gnt_found) begin
      ptr_d        = rr_index(gnt_idx, 1);
      grant_idx_d  = gnt_idx;
      reg_num_w_d  = sel_rd;
      w_data_d     = sel_data;
      ctrl_reg_w_d = (sel_rd != 5'd0);
      if (sel_rd != 5'd0) busy_d[sel_rd] = 1'b0;
    end
    // Applied after the clear so a same-edge re-issue keeps the register busy.
    if (iss_valid && iss_rd != 5'd0) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      ptr_q        <= '0;
      grant_idx_q  <= '0;
      reg_num_w_q  <= '0;
      w_data_q     <= '0;
      ctrl_reg_w_q <= 1'b0;
      // NOTE: the scoreboard is a flop array, not RAM, so clearing it on reset is cheap and required.
      busy_q       <= '0;
    end else begin
      ptr_q        <= ptr_d;
      grant_idx_q  <= grant_idx_d;
      reg_num_w_q  <= reg_num_w_d;
      w_data_q     <= w_data_d;
      ctrl_reg_w_q <= ctrl_reg_w_d;
      busy_q       <= busy_d;
    end
  end

  assign reg_num_w  = reg_num_w_q;
  assign w_data     = w_data_q;
  assign ctrl_reg_w = ctrl_reg_w_q;
  assign grant_idx  = grant_idx_q;

  // The in-flight term covers the cycle before the register file captures the write.
  assign busy_rs1 = rst_n && (chk_rs1 != 5'd0) &&
                    (busy_q[chk_rs1] || (ctrl_reg_w_q && reg_num_w_q == chk_rs1));
  assign busy_rs2 = rst_n && (chk_rs2 != 5'd0) &&
                    (busy_q[chk_rs2] || (ctrl_reg_w_q && reg_num_w_q == chk_rs2));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 64;
  localparam int PW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [4:0]           rd_a [NREQ];
  logic [XLEN-1:0]      data_a [NREQ];
  logic [5*NREQ-1:0]    req_rd;
  logic [XLEN*NREQ-1:0] req_data;
  logic [4:0]           reg_num_w;
  logic [XLEN-1:0]      w_data;
  logic                 ctrl_reg_w;
  logic [PW-1:0]        grant_idx;
  logic                 iss_valid;
  logic [4:0]           iss_rd, chk_rs1, chk_rs2;
  logic                 busy_rs1, busy_rs2;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int           m_ptr, m_gidx;
  logic [4:0]   m_reg;
  logic [63:0]  m_data;
  bit           m_wen;
  bit           m_busy [32];

  always #5 clk = ~clk;

  always_comb begin
    req_rd   = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[5*i +: 5]          = rd_a[i];
      req_data[XLEN*i +: XLEN]  = data_a[i];
    end
  end

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .reg_num_w(reg_num_w), .w_data(w_data), .ctrl_reg_w(ctrl_reg_w),
    .grant_idx(grant_idx),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid requester at or after the pointer, wrapping; -1 if none.
  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit model_busy(input logic [4:0] chk);
    if (!rst_n || chk == 5'd0) return 1'b0;
    return m_busy[chk] || (m_wen && m_reg == chk);
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_gidx = 0; m_reg = '0; m_data = '0; m_wen = 1'b0;
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
  endtask

  task automatic model_update();
    int g;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g = model_pick();
    if (g >= 0) begin
      m_ptr  = (g + 1) % NREQ;
      m_gidx = g;
      m_reg  = rd_a[g];
      m_data = data_a[g];
      m_wen  = (rd_a[g] != 5'd0);
      if (rd_a[g] != 5'd0) m_busy[rd_a[g]] = 1'b0;
    end else begin
      m_wen = 1'b0;
    end
    if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
  endtask

  task automatic compare_all();
    int g;
    logic [NREQ-1:0] exp_ready;
    g = model_pick();
    exp_ready = (rst_n && g >= 0) ? NREQ'(1 << g) : '0;
    check("req_ready",  req_ready,  exp_ready);
    check("ctrl_reg_w", ctrl_reg_w, m_wen);
    check("reg_num_w",  reg_num_w,  m_reg);
    check("w_data",     w_data,     m_data);
    check("grant_idx",  grant_idx,  m_gidx);
    check("busy_rs1",   busy_rs1,   model_busy(chk_rs1));
    check("busy_rs2",   busy_rs2,   model_busy(chk_rs2));
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic run_cycle();
    #1;
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_idle();
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd_a[i]   = '0;
      data_a[i] = '0;
    end
    iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    @(negedge clk);

    // Reset values, with busy[5] set beforehand and all inputs active during reset
    rst_n = 1'b1; iss_valid = 1'b1; iss_rd = 5'd5;
    run_cycle();
    rst_n = 1'b0;
    req_valid = '1;
    rd_a[0] = 5'd3; rd_a[1] = 5'd6; rd_a[2] = 5'd8;
    for (int i = 0; i < NREQ; i++) data_a[i] = {$urandom, $urandom};
    chk_rs1 = 5'd5; chk_rs2 = 5'd5;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rst_ready", req_ready, 3'b000);
      check("rst_busy_rs1", busy_rs1, 1'b0);
      run_cycle();
    end
    check("rst_ctrl", ctrl_reg_w, 1'b0);
    check("rst_reg", reg_num_w, 5'd0);
    check("rst_data", w_data, 64'd0);
    check("rst_gidx", grant_idx, 2'd0);
    set_idle(); rst_n = 1'b1; chk_rs1 = 5'd5;
    #1 check("rst_busy5_cleared", busy_rs1, 1'b0);
    run_cycle();

    // Single write from requester 1
    req_valid = 3'b010; rd_a[1] = 5'd7; data_a[1] = 64'hDEAD_BEEF;
    #1 check("single_ready", req_ready, 3'b010);
    run_cycle();
    check("single_ctrl", ctrl_reg_w, 1'b1);
    check("single_reg", reg_num_w, 5'd7);
    check("single_data", w_data, 64'hDEAD_BEEF);
    check("single_gidx", grant_idx, 2'd1);
    set_idle();

    // Round robin from ptr = 0
    rst_n = 1'b0;
    run_cycle();
    rst_n = 1'b1;
    req_valid = '1; rd_a[0] = 5'd10; rd_a[1] = 5'd11; rd_a[2] = 5'd12;
    for (int k = 0; k < 6; k++) begin
      run_cycle();
      check("rr_order", grant_idx, 64'(k % NREQ));
    end
    set_idle();

    // x0 write: consumed, no write enable, busy untouched
    iss_valid = 1'b1; iss_rd = 5'd3;
    run_cycle();
    set_idle();
    req_valid = 3'b001; rd_a[0] = 5'd0; data_a[0] = 64'h1234_5678_9ABC_DEF0;
    #1 check("x0_ready", req_ready, 3'b001);
    run_cycle();
    check("x0_ctrl", ctrl_reg_w, 1'b0);
    check("x0_gidx", grant_idx, 2'd0);
    set_idle(); chk_rs1 = 5'd3;
    #1 check("x0_busy3_kept", busy_rs1, 1'b1);
    run_cycle();

    // Scoreboard lifecycle on rd = 9
    set_idle(); chk_rs1 = 5'd9; iss_valid = 1'b1; iss_rd = 5'd9;
    #1 check("sb_before_issue", busy_rs1, 1'b0);
    run_cycle();
    iss_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1 check("sb_pending", busy_rs1, 1'b1);
      run_cycle();
    end
    req_valid = 3'b100; rd_a[2] = 5'd9; data_a[2] = 64'hCAFE;
    #1 check("sb_grant_cycle", busy_rs1, 1'b1);
    run_cycle();
    req_valid = '0;
    check("sb_wr_ctrl", ctrl_reg_w, 1'b1);
    check("sb_wr_reg", reg_num_w, 5'd9);
    #1 check("sb_in_flight", busy_rs1, 1'b1);
    run_cycle();
    #1 check("sb_done", busy_rs1, 1'b0);
    run_cycle();
    iss_valid = 1'b1; iss_rd = 5'd9; req_valid = 3'b100; rd_a[2] = 5'd9;
    run_cycle();
    iss_valid = 1'b0; req_valid = '0;
    run_cycle();
    #1 check("sb_set_wins", busy_rs1, 1'b1);
    req_valid = 3'b100;
    run_cycle();
    set_idle();
    run_cycle();

    // Reset on a grant edge for rd = 4
    iss_valid = 1'b1; iss_rd = 5'd4;
    run_cycle();
    iss_valid = 1'b0; req_valid = 3'b001; rd_a[0] = 5'd4; chk_rs1 = 5'd4;
    rst_n = 1'b0;
    #1 check("midrst_ready", req_ready, 3'b000);
    run_cycle();
    set_idle(); rst_n = 1'b1; chk_rs1 = 5'd4;
    check("midrst_ctrl", ctrl_reg_w, 1'b0);
    #1 check("midrst_busy4", busy_rs1, 1'b0);
    run_cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        rd_a[i]   = 5'($urandom_range(0, 7));
        data_a[i] = {$urandom, $urandom};
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom_range(0, 7));
      chk_rs1   = 5'($urandom_range(0, 7));
      chk_rs2   = 5'($urandom_range(0, 7));
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
